debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- N-channel successor to the single-button debouncer: synchronises, debounces and edge-detects every button/switch input in one block.
- Per channel: level-clean output, one-cycle rise/fall pulses, and a "press" strobe with optional hold-to-repeat.
- Sits between raw board pins (btn*, sw, jb) and consumers such as game_fsm, the tx trigger and the cursor/menu logic, in the 65 MHz domain.

Parameters:
- N_CH, 5, number of independent channels.
- STABLE_CYCLES, 1000000, consecutive stable cycles required before clean level changes; legal range >= 1.
- SYNC_STAGES, 2, flops in the per-channel synchroniser; legal range >= 2.
- REPEAT_DELAY, 32500000, cycles clean must stay high before the first repeat strobe. Used only with the macro.
- REPEAT_PERIOD, 6500000, cycles between subsequent repeat strobes. Used only with the macro.

Ports:
- clk_in, input, 1, system clock (65 MHz).
- rst_in, input, 1, synchronous active-high reset.
- noisy_in, input, N_CH, raw asynchronous inputs.
- clean_out, output, N_CH, debounced level.
- rise_out, output, N_CH, one-cycle pulse on a clean 0->1 transition.
- fall_out, output, N_CH, one-cycle pulse on a clean 1->0 transition.
- press_out, output, N_CH, one-cycle press strobe; includes repeats when the macro is defined.

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high. All state is updated on posedge clk_in only.
- Channels are fully independent. There is no cross-channel interaction.
- Reset cycle:
  - All sync stages, the candidate register and clean_out[i] load noisy_in[i] directly.
  - Stability counter clears to 0.
  - rise_out, fall_out and press_out are 0.
  - Repeat FSM goes to IDLE.
  - Consequence: no edge pulse is generated for a level already present at reset.
- Synchroniser: noisy_in[i] passes through SYNC_STAGES flops; sync_q is the last stage.
- Stability counter, priority order each cycle:
  - sync_q != candidate: candidate <= sync_q, count <= 0.
  - else count == STABLE_CYCLES-1: clean_out <= candidate; count holds (saturates, never wraps).
  - else: count <= count+1.
- Counter width: $clog2(STABLE_CYCLES+1), computed as a localparam.
- Latency: a raw step that is first sampled at edge r appears on clean_out after edge r+SYNC_STAGES+STABLE_CYCLES.
- Glitch rejection: any toggle shorter than STABLE_CYCLES cycles at sync_q restarts the count and never reaches clean_out.
- Edge pulses:
  - rise_out[i] is registered on the same edge that clean_out[i] goes 0->1, so it is high during clean_out's first high cycle.
  - fall_out[i] behaves the same way for 1->0.
  - Each pulse lasts exactly 1 cycle.
- press_out[i] equals rise_out[i] when the macro is absent.
- A reset asserted mid-count discards the partial count. clean_out adopts the raw level with no pulse.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined: per-channel repeat FSM with states IDLE, HOLD, REPEAT.
  - IDLE -> HOLD on rise_out; press_out pulses on this edge; repeat counter <= 0.
  - HOLD: counter increments. On reaching REPEAT_DELAY-1, press_out pulses 1 cycle, counter <= 0, -> REPEAT.
  - REPEAT: press_out pulses every REPEAT_PERIOD cycles.
  - Any state -> IDLE when clean_out falls, with no pulse on that edge. A fall always wins over a coincident repeat strobe.
- Undefined: no repeat counters or FSM are synthesised; press_out = rise_out; the REPEAT_* parameters are ignored.

Decomposition:
- Package debounce_pkg holds:
  - default constants DB_STABLE_65MHZ=1000000, DB_REPEAT_DELAY_65MHZ=32500000, DB_REPEAT_PERIOD_65MHZ=6500000;
  - enum repeat_state_t {IDLE, HOLD, REPEAT}.
- Sub-module debounce_chan implements one channel: sync, counter, edges and repeat FSM, with the same parameters minus N_CH.
- debounce_bank is a generate loop of N_CH debounce_chan instances.

Test Plan (bench parameters: N_CH=2, STABLE_CYCLES=8, SYNC_STAGES=2, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Reset with noisy_in=2'b10, held 1 cycle then released -> clean_out=2'b10 on the first post-reset cycle; no rise/fall/press pulses at any point.
- Clean step noisy_in[0] 0->1 first sampled at edge r -> clean_out[0] rises after edge r+10; rise_out[0] and press_out[0] are high exactly 1 cycle, coincident; channel 1 stays unaffected.
- Bounce: noisy_in[0] toggled every 3 cycles for 40 cycles, then held 1 -> clean_out[0] changes once, 10 cycles after the final toggle is sampled; exactly 1 rise pulse.
- Release: noisy_in[0] 1->0 held stable -> fall_out[0] pulses once; press_out[0] stays 0.
- Reset asserted when count=5 during a 0->1 change -> clean_out[0]=1 immediately after reset; rise_out stays 0.
- With DEBOUNCE_REPEAT_EN, hold noisy_in[0]=1 for 60 cycles past clean rise -> press_out pulses at clean-rise, +20, +25, +30, ...; release -> no further pulses; FSM returns to IDLE.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and repeat-FSM state type for the debounce bank.
package debounce_pkg;

    localparam int unsigned DB_STABLE_65MHZ        = 1000000;
    localparam int unsigned DB_REPEAT_DELAY_65MHZ  = 32500000;
    localparam int unsigned DB_REPEAT_PERIOD_65MHZ = 6500000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } repeat_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, edge pulses and press strobe.
// Hold-to-repeat on press_out is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DB_STABLE_65MHZ,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned REPEAT_DELAY  = DB_REPEAT_DELAY_65MHZ,
    parameter int unsigned REPEAT_PERIOD = DB_REPEAT_PERIOD_65MHZ
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic noisy_in,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out,
    output logic press_out
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    if (STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("debounce_chan: illegal STABLE_CYCLES or SYNC_STAGES");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic                   cand_r, cand_d;
    logic [CNT_W-1:0]       count_r, count_d;
    logic                   clean_r, clean_d;
    logic                   rise_r, rise_d;
    logic                   fall_r, fall_d;

    assign sync_q = sync_r[SYNC_STAGES-1];

    // Reset preloads the pipeline with the raw level so no edge is seen for it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_r  <= {SYNC_STAGES{noisy_in}};
            cand_r  <= noisy_in;
            count_r <= '0;
            clean_r <= noisy_in;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], noisy_in};
            cand_r  <= cand_d;
            count_r <= count_d;
            clean_r <= clean_d;
            rise_r  <= rise_d;
            fall_r  <= fall_d;
        end
    end

    // Any change at sync_q restarts the count; the count saturates once stable.
    always_comb begin
        cand_d  = cand_r;
        count_d = count_r;
        clean_d = clean_r;
        if (sync_q != cand_r) begin
            cand_d  = sync_q;
            count_d = '0;
        end else if (count_r == CNT_W'(STABLE_CYCLES - 1)) begin
            clean_d = cand_r;
        end else begin
            count_d = count_r + CNT_W'(1);
        end
        rise_d = clean_d & ~clean_r;
        fall_d = ~clean_d & clean_r;
    end

    assign clean_out = clean_r;
    assign rise_out  = rise_r;
    assign fall_out  = fall_r;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
        $error("debounce_chan: illegal REPEAT_DELAY or REPEAT_PERIOD");
    end

    repeat_state_t    state_r, state_d;
    logic [RPT_W-1:0] rpt_cnt_r, rpt_cnt_d;
    logic             press_r, press_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r   <= IDLE;
            rpt_cnt_r <= '0;
            press_r   <= 1'b0;
        end else begin
            state_r   <= state_d;
            rpt_cnt_r <= rpt_cnt_d;
            press_r   <= press_d;
        end
    end

    // A clean fall always returns to IDLE and suppresses a coincident repeat.
    always_comb begin
        state_d   = state_r;
        rpt_cnt_d = rpt_cnt_r;
        press_d   = 1'b0;
        if (fall_d) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_d) begin
                        state_d   = HOLD;
                        rpt_cnt_d = '0;
                        press_d   = 1'b1;
                    end
                end
                HOLD: begin
                    if (rpt_cnt_r == RPT_W'(REPEAT_DELAY - 1)) begin
                        state_d   = REPEAT;
                        rpt_cnt_d = '0;
                        press_d   = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_r + RPT_W'(1);
                    end
                end
                REPEAT: begin
                    if (rpt_cnt_r == RPT_W'(REPEAT_PERIOD - 1)) begin
                        rpt_cnt_d = '0;
                        press_d   = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_r + RPT_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    assign press_out = press_r;
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
        $error("debounce_chan: illegal REPEAT_DELAY or REPEAT_PERIOD");
    end

    assign press_out = rise_r;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels sharing clk_in/rst_in.
// Optional hold-to-repeat press strobes: DEBOUNCE_REPEAT_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned STABLE_CYCLES = DB_STABLE_65MHZ,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned REPEAT_DELAY  = DB_REPEAT_DELAY_65MHZ,
    parameter int unsigned REPEAT_PERIOD = DB_REPEAT_PERIOD_65MHZ
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out,
    output logic [N_CH-1:0] press_out
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .noisy_in (noisy_in[i]),
            .clean_out(clean_out[i]),
            .rise_out (rise_out[i]),
            .fall_out (fall_out[i]),
            .press_out(press_out[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with short debounce/repeat timing.
module tb_debounce_bank;

    localparam int unsigned N_CH = 2;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int EXP_RPT_N = 11;
`else
    localparam int EXP_RPT_N = 0;
`endif

    logic            clk_in;
    logic            rst_in;
    logic [N_CH-1:0] noisy_in;
    logic [N_CH-1:0] clean_out;
    logic [N_CH-1:0] rise_out;
    logic [N_CH-1:0] fall_out;
    logic [N_CH-1:0] press_out;

    int n_checks;
    int n_errors;
    int rise_cnt0;
    int fall_cnt0;
    int press_cnt0;
    int edge_cnt1;
    int press_q[$];

    debounce_bank #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(8),
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5)
    ) u_dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .noisy_in (noisy_in),
        .clean_out(clean_out),
        .rise_out (rise_out),
        .fall_out (fall_out),
        .press_out(press_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, sample just after the edge, and tally pulses.
    task automatic step();
        @(posedge clk_in);
        #1;
        if (rise_out[0])  rise_cnt0++;
        if (fall_out[0])  fall_cnt0++;
        if (press_out[0]) press_cnt0++;
        if (rise_out[1] || fall_out[1] || press_out[1]) edge_cnt1++;
    endtask

    task automatic clear_counts();
        rise_cnt0  = 0;
        fall_cnt0  = 0;
        press_cnt0 = 0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        edge_cnt1 = 0;
        clear_counts();

        // Reset with levels already present: adopt them, no pulses.
        rst_in   = 1'b1;
        noisy_in = 2'b10;
        step();
        rst_in = 1'b0;
        check("rst_clean", 32'(clean_out), 32'h2);
        check("rst_rise",  32'(rise_out),  32'h0);
        check("rst_fall",  32'(fall_out),  32'h0);
        check("rst_press", 32'(press_out), 32'h0);
        repeat (20) step();
        check("rst_hold_clean", 32'(clean_out), 32'h2);
        check("rst_no_pulses",  32'(rise_cnt0 + fall_cnt0 + press_cnt0), 32'd0);

        // Clean 0->1 step on channel 0: visible 10 edges after first sample.
        clear_counts();
        noisy_in[0] = 1'b1;
        repeat (10) step();
        check("step_not_yet", 32'(clean_out[0]), 32'd0);
        step();
        check("step_clean", 32'(clean_out), 32'h3);
        check("step_rise",  32'(rise_out),  32'h1);
        check("step_press", 32'(press_out), 32'h1);
        step();
        check("step_rise_1cyc",  32'(rise_out),  32'h0);
        check("step_press_1cyc", 32'(press_out), 32'h0);

        // Release: one fall pulse, no press.
        noisy_in[0] = 1'b0;
        repeat (10) step();
        check("rel_not_yet", 32'(clean_out[0]), 32'd1);
        step();
        check("rel_clean", 32'(clean_out), 32'h2);
        check("rel_fall",  32'(fall_out),  32'h1);
        check("rel_press", 32'(press_out), 32'h0);
        step();
        check("rel_fall_1cyc", 32'(fall_out),   32'h0);
        check("rel_fall_cnt",  32'(fall_cnt0),  32'd1);
        check("rel_press_cnt", 32'(press_cnt0), 32'd1);

        // Bounce: 3-cycle toggles are rejected; final level wins once.
        clear_counts();
        for (int t = 0; t < 13; t++) begin
            noisy_in[0] = ~noisy_in[0];
            if (t != 12) repeat (3) step();
        end
        repeat (10) step();
        check("bnc_not_yet", 32'(clean_out[0]), 32'd0);
        check("bnc_no_early_rise", 32'(rise_cnt0), 32'd0);
        step();
        check("bnc_clean", 32'(clean_out[0]), 32'd1);
        check("bnc_rise",  32'(rise_out[0]),  32'd1);
        repeat (3) step();
        check("bnc_rise_cnt", 32'(rise_cnt0), 32'd1);
        check("bnc_fall_cnt", 32'(fall_cnt0), 32'd0);
        noisy_in[0] = 1'b0;
        repeat (15) step();
        check("bnc_released", 32'(clean_out[0]), 32'd0);

        // Reset while count=5 on a 0->1 change: adopt raw level, no pulse.
        noisy_in[0] = 1'b1;
        repeat (8) step();
        check("mid_pre_clean", 32'(clean_out[0]), 32'd0);
        clear_counts();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("mid_clean", 32'(clean_out), 32'h3);
        check("mid_rise",  32'(rise_out),  32'h0);
        repeat (15) step();
        check("mid_hold_clean", 32'(clean_out), 32'h3);
        check("mid_no_pulses",  32'(rise_cnt0 + fall_cnt0 + press_cnt0), 32'd0);

        // Hold-to-repeat, released so the fall coincides with a repeat slot.
        noisy_in[0] = 1'b0;
        repeat (15) step();
        check("rpt_pre_clean", 32'(clean_out[0]), 32'd0);
        noisy_in[0] = 1'b1;
        repeat (11) step();
        check("rpt_rise",  32'(rise_out[0]),  32'd1);
        check("rpt_press", 32'(press_out[0]), 32'd1);
        for (int k = 1; k <= 100; k++) begin
            step();
            if (press_out[0]) press_q.push_back(k);
            if (k == 64) noisy_in[0] = 1'b0;
            if (k == 75) begin
                check("rpt_fall",       32'(fall_out[0]),  32'd1);
                check("rpt_fall_press", 32'(press_out[0]), 32'd0);
            end
        end
        check("rpt_count", 32'(press_q.size()), 32'(EXP_RPT_N));
        for (int i = 0; i < press_q.size() && i < EXP_RPT_N; i++)
            check($sformatf("rpt_slot%0d", i), 32'(press_q[i]), 32'(20 + 5 * i));

        check("ch1_no_pulses", 32'(edge_cnt1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
